// File: rtl/cpu_state_pkg.sv
// rtl/cpu_state_pkg.sv - shared state encodings and defaults for the CPU controller state register
package cpu_state_pkg;

  localparam int CPU_STATE_W = 4;

  typedef enum logic [CPU_STATE_W-1:0] {
    S_FLUSH   = 4'h0,
    S_DECODE  = 4'h1,
    S_EXEC    = 4'h2,
    S_MEM_RD  = 4'h3,
    S_MEM_WR  = 4'h4,
    S_WB      = 4'h5,
    S_BRANCH  = 4'h6,
    S_HALT    = 4'h7,
    S_FETCH   = 4'hF
  } cpu_state_e;

  localparam logic [CPU_STATE_W-1:0] DEF_RESET_STATE = S_FETCH;
  localparam logic [CPU_STATE_W-1:0] DEF_FLUSH_STATE = S_FLUSH;

endpackage

// File: rtl/state_hist_buf.sv
// rtl/state_hist_buf.sv - ring of recently left states with newest-first indexed read
module state_hist_buf
  import cpu_state_pkg::*;
#(
  parameter int                  STATE_W   = CPU_STATE_W,
  parameter int                  DEPTH     = 4,
  parameter logic [STATE_W-1:0]  EMPTY_VAL = STATE_W'(DEF_RESET_STATE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [STATE_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [STATE_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int              IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0]  FULL  = (IDX_W+1)'(DEPTH);

  logic [STATE_W-1:0] ring_q [DEPTH];
  logic [STATE_W-1:0] ring_d [DEPTH];
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr;
  logic [IDX_W:0]     count_q, count_d;

  always_comb begin
    ring_d   = ring_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      ring_d[wr_ptr_q] = wr_data;
      wr_ptr_d         = wr_ptr_q + IDX_W'(1);
      if (count_q != FULL) count_d = count_q + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ring_q   <= ring_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // DEPTH is a power of two, so the pointer arithmetic wraps for free
  always_comb begin
    rd_ptr  = wr_ptr_q - IDX_W'(1) - rd_idx;
    rd_data = ({1'b0, rd_idx} < count_q) ? ring_q[rd_ptr] : EMPTY_VAL;
  end

  assign count = count_q;

endmodule

// File: rtl/state_reg_ctrl.sv
// rtl/state_reg_ctrl.sv - current-state register with pause, single-step, flush, dwell count and history
module state_reg_ctrl
  import cpu_state_pkg::*;
#(
  parameter int                  STATE_W     = CPU_STATE_W,
  parameter logic [STATE_W-1:0]  RESET_STATE = STATE_W'(DEF_RESET_STATE),
  parameter logic [STATE_W-1:0]  FLUSH_STATE = STATE_W'(DEF_FLUSH_STATE),
  parameter int                  HIST_DEPTH  = 4,
  parameter int                  CNT_W       = 8
) (
  input  logic                            multi_clk,
  input  logic                            rst,
  input  logic                            pause,
  input  logic                            step_en,
  input  logic                            step_req,
  input  logic                            flush,
  input  logic [STATE_W-1:0]              next_state,
  input  logic [$clog2(HIST_DEPTH)-1:0]   hist_rd_idx,
  output logic [STATE_W-1:0]              current_state,
  output logic [STATE_W-1:0]              prev_state,
  output logic                            state_changed,
  output logic [CNT_W-1:0]                dwell_cnt,
  output logic [$clog2(HIST_DEPTH):0]     hist_count,
  output logic [STATE_W-1:0]              hist_rd_state
);

  logic [STATE_W-1:0] cur_q, cur_d, prev_q, prev_d, load_val;
  logic               changed_q, changed_d, step_req_q;
  logic               step_pulse, adv, load, change;
  logic [CNT_W-1:0]   dwell_q, dwell_d;

  always_comb begin
    step_pulse = step_req & ~step_req_q;
    adv        = ~pause & (~step_en | step_pulse);
    load       = flush | adv;
    load_val   = flush ? FLUSH_STATE : next_state;
    // a load that targets the current state is a self-loop and counts as a hold
    change     = load && (load_val != cur_q);

    cur_d     = cur_q;
    prev_d    = prev_q;
    changed_d = 1'b0;
    dwell_d   = (dwell_q == '1) ? dwell_q : dwell_q + CNT_W'(1);
    if (change) begin
      cur_d     = load_val;
      prev_d    = cur_q;
      changed_d = 1'b1;
      dwell_d   = '0;
    end
  end

  always_ff @(posedge multi_clk or posedge rst) begin
    if (rst) begin
      cur_q      <= RESET_STATE;
      prev_q     <= RESET_STATE;
      changed_q  <= 1'b0;
      dwell_q    <= '0;
      step_req_q <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      changed_q  <= changed_d;
      dwell_q    <= dwell_d;
      step_req_q <= step_req;
    end
  end

  state_hist_buf #(
    .STATE_W   (STATE_W),
    .DEPTH     (HIST_DEPTH),
    .EMPTY_VAL (RESET_STATE)
  ) u_hist (
    .clk     (multi_clk),
    .rst     (rst),
    .wr_en   (change),
    .wr_data (cur_q),
    .rd_idx  (hist_rd_idx),
    .rd_data (hist_rd_state),
    .count   (hist_count)
  );

  assign current_state = cur_q;
  assign prev_state    = prev_q;
  assign state_changed = changed_q;
  assign dwell_cnt     = dwell_q;

endmodule

// File: tb/tb_state_reg_ctrl.sv
// tb/tb_state_reg_ctrl.sv - scoreboard bench for state_reg_ctrl
module tb_state_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst, pause, step_en, step_req, flush;
  logic [3:0] next_state;
  logic [1:0] hist_rd_idx;

  logic [3:0] current_state, prev_state, hist_rd_state;
  logic       state_changed;
  logic [7:0] dwell_cnt;
  logic [2:0] hist_count;

  logic [3:0] c3_current_state, c3_prev_state, c3_hist_rd_state;
  logic       c3_state_changed;
  logic [2:0] c3_dwell_cnt;
  logic [2:0] c3_hist_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] cur;
    logic [3:0] prev;
    logic       chg;
    logic [7:0] dwell;
    logic [2:0] dwell3;
    logic [2:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  logic [3:0] m_cur, m_prev;
  logic       m_chg, m_step_q;
  int         m_dwell, m_dwell3, m_wp, m_cnt;
  logic [3:0] m_ring [4];

  always #5 clk = ~clk;

  state_reg_ctrl dut (
    .multi_clk(clk), .rst(rst), .pause(pause), .step_en(step_en), .step_req(step_req),
    .flush(flush), .next_state(next_state), .hist_rd_idx(hist_rd_idx),
    .current_state(current_state), .prev_state(prev_state), .state_changed(state_changed),
    .dwell_cnt(dwell_cnt), .hist_count(hist_count), .hist_rd_state(hist_rd_state)
  );

  state_reg_ctrl #(.CNT_W(3)) dut_c3 (
    .multi_clk(clk), .rst(rst), .pause(pause), .step_en(step_en), .step_req(step_req),
    .flush(flush), .next_state(next_state), .hist_rd_idx(hist_rd_idx),
    .current_state(c3_current_state), .prev_state(c3_prev_state), .state_changed(c3_state_changed),
    .dwell_cnt(c3_dwell_cnt), .hist_count(c3_hist_count), .hist_rd_state(c3_hist_rd_state)
  );

  // scoreboard consumer: one expected entry per active edge
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++; if (current_state !== e.cur) begin errors++; $display("FAIL sb_cur got %h exp %h", current_state, e.cur); end
      checks++; if (prev_state !== e.prev) begin errors++; $display("FAIL sb_prev got %h exp %h", prev_state, e.prev); end
      checks++; if (state_changed !== e.chg) begin errors++; $display("FAIL sb_changed got %b exp %b", state_changed, e.chg); end
      checks++; if (dwell_cnt !== e.dwell) begin errors++; $display("FAIL sb_dwell got %0d exp %0d", dwell_cnt, e.dwell); end
      checks++; if (c3_dwell_cnt !== e.dwell3) begin errors++; $display("FAIL sb_dwell3 got %0d exp %0d", c3_dwell_cnt, e.dwell3); end
      checks++; if (hist_count !== e.cnt) begin errors++; $display("FAIL sb_hist_count got %0d exp %0d", hist_count, e.cnt); end
    end
  end

  task automatic model_reset();
    m_cur = 4'hF; m_prev = 4'hF; m_chg = 1'b0; m_step_q = 1'b0;
    m_dwell = 0; m_dwell3 = 0; m_wp = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) m_ring[i] = 4'h0;
  endtask

  // advance the model on the driven inputs, push its prediction, then run one edge
  task automatic cycle();
    logic       sp, adv, ld;
    logic [3:0] lv;
    exp_t       e;
    sp  = step_req & ~m_step_q;
    adv = ~pause & (~step_en | sp);
    ld  = flush | adv;
    lv  = flush ? 4'h0 : next_state;
    if (ld && lv != m_cur) begin
      m_ring[m_wp] = m_cur;
      m_wp   = (m_wp + 1) % 4;
      m_cnt  = (m_cnt < 4) ? m_cnt + 1 : 4;
      m_prev = m_cur; m_cur = lv; m_chg = 1'b1; m_dwell = 0; m_dwell3 = 0;
    end else begin
      m_chg    = 1'b0;
      m_dwell  = (m_dwell  < 255) ? m_dwell + 1 : 255;
      m_dwell3 = (m_dwell3 < 7)   ? m_dwell3 + 1 : 7;
    end
    m_step_q = step_req;
    e.cur = m_cur; e.prev = m_prev; e.chg = m_chg;
    e.dwell = 8'(m_dwell); e.dwell3 = 3'(m_dwell3); e.cnt = 3'(m_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (current_state !== 4'hF) begin errors++; $display("FAIL rst_cur got %h exp f", current_state); end
    checks++; if (prev_state !== 4'hF) begin errors++; $display("FAIL rst_prev got %h exp f", prev_state); end
    checks++; if (state_changed !== 1'b0) begin errors++; $display("FAIL rst_changed got %b exp 0", state_changed); end
    checks++; if (dwell_cnt !== 8'd0) begin errors++; $display("FAIL rst_dwell got %0d exp 0", dwell_cnt); end
    checks++; if (hist_count !== 3'd0) begin errors++; $display("FAIL rst_hist_count got %0d exp 0", hist_count); end
    checks++; if (hist_rd_state !== 4'hF) begin errors++; $display("FAIL rst_hist_rd got %h exp f", hist_rd_state); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequence();
    logic [3:0] eh [4];
    pause = 0; step_en = 0; step_req = 0; flush = 0;
    for (int s = 1; s <= 3; s++) begin
      next_state = 4'(s);
      cycle();
    end
    checks++; if (current_state !== 4'h3) begin errors++; $display("FAIL seq_cur got %h exp 3", current_state); end
    checks++; if (prev_state !== 4'h2) begin errors++; $display("FAIL seq_prev got %h exp 2", prev_state); end
    eh = '{4'h2, 4'h1, 4'hF, 4'hF};
    for (int i = 0; i < 4; i++) begin
      hist_rd_idx = 2'(i);
      #1;
      checks++; if (hist_rd_state !== eh[i]) begin errors++; $display("FAIL seq_hist%0d got %h exp %h", i, hist_rd_state, eh[i]); end
    end
    hist_rd_idx = 2'd0;
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    #2;
    checks++; if (current_state !== 4'hF) begin errors++; $display("FAIL arst_cur got %h exp f", current_state); end
    checks++; if (dwell_cnt !== 8'd0) begin errors++; $display("FAIL arst_dwell got %0d exp 0", dwell_cnt); end
    checks++; if (hist_count !== 3'd0) begin errors++; $display("FAIL arst_hist_count got %0d exp 0", hist_count); end
    checks++; if (hist_rd_state !== 4'hF) begin errors++; $display("FAIL arst_hist_rd got %h exp f", hist_rd_state); end
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_pause();
    pause = 1; next_state = 4'h7;
    repeat (5) cycle();
    checks++; if (current_state !== 4'hF) begin errors++; $display("FAIL pause_cur got %h exp f", current_state); end
    checks++; if (dwell_cnt !== 8'd5) begin errors++; $display("FAIL pause_dwell5 got %0d exp 5", dwell_cnt); end
    repeat (5) cycle();
    checks++; if (dwell_cnt !== 8'd10) begin errors++; $display("FAIL pause_dwell10 got %0d exp 10", dwell_cnt); end
    checks++; if (c3_dwell_cnt !== 3'd7) begin errors++; $display("FAIL pause_dwell3_sat got %0d exp 7", c3_dwell_cnt); end
  endtask

  task automatic test_step();
    pause = 0; step_en = 1; step_req = 0; next_state = 4'h9;
    cycle();
    step_req = 1;
    repeat (4) cycle();
    checks++; if (current_state !== 4'h9) begin errors++; $display("FAIL step_one_cur got %h exp 9", current_state); end
    checks++; if (dwell_cnt !== 8'd3) begin errors++; $display("FAIL step_one_dwell got %0d exp 3", dwell_cnt); end
    step_req = 0; next_state = 4'hA;
    cycle();
    step_req = 1;
    cycle();
    checks++; if (current_state !== 4'hA) begin errors++; $display("FAIL step_two_cur got %h exp a", current_state); end
    checks++; if (prev_state !== 4'h9) begin errors++; $display("FAIL step_two_prev got %h exp 9", prev_state); end
    step_req = 0;
    cycle();
    pause = 1; step_req = 1; next_state = 4'hB;
    cycle();
    pause = 0;
    cycle();
    checks++; if (current_state !== 4'hA) begin errors++; $display("FAIL step_lost_cur got %h exp a", current_state); end
    step_req = 0; step_en = 0;
  endtask

  task automatic test_flush();
    next_state = 4'h5;
    cycle();
    pause = 1; flush = 1; next_state = 4'h8;
    cycle();
    checks++; if (current_state !== 4'h0) begin errors++; $display("FAIL flush_cur got %h exp 0", current_state); end
    checks++; if (prev_state !== 4'h5) begin errors++; $display("FAIL flush_prev got %h exp 5", prev_state); end
    checks++; if (state_changed !== 1'b1) begin errors++; $display("FAIL flush_changed got %b exp 1", state_changed); end
    cycle();
    checks++; if (state_changed !== 1'b0) begin errors++; $display("FAIL flush_self_changed got %b exp 0", state_changed); end
    checks++; if (prev_state !== 4'h5) begin errors++; $display("FAIL flush_self_prev got %h exp 5", prev_state); end
    pause = 0; flush = 0;
  endtask

  task automatic test_hist_wrap();
    logic [3:0] eh [4];
    for (int s = 1; s <= 6; s++) begin
      next_state = 4'(s);
      cycle();
    end
    cycle();
    checks++; if (hist_count !== 3'd4) begin errors++; $display("FAIL wrap_count got %0d exp 4", hist_count); end
    eh = '{4'h5, 4'h4, 4'h3, 4'h2};
    for (int i = 0; i < 4; i++) begin
      hist_rd_idx = 2'(i);
      #1;
      checks++; if (hist_rd_state !== eh[i]) begin errors++; $display("FAIL wrap_hist%0d got %h exp %h", i, hist_rd_state, eh[i]); end
      checks++; if (hist_rd_state !== m_ring[(m_wp + 3 - i) % 4]) begin errors++; $display("FAIL wrap_model%0d got %h exp %h", i, hist_rd_state, m_ring[(m_wp + 3 - i) % 4]); end
    end
    hist_rd_idx = 2'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pause = 0; step_en = 0; step_req = 0; flush = 0;
    next_state = 4'h0; hist_rd_idx = 2'd0;
    model_reset();
    test_reset();
    test_sequence();
    test_async_reset();
    test_pause();
    test_step();
    test_flush();
    test_hist_wrap();
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain got %0d exp 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
